flit_depacketer: RTL and testbench
==================================

Name: flit_depacketer

Overview:
- Ejection-side counterpart of the flit packer: takes 82-bit flits from the router's local ejection port and splits them back into their header fields and payload for the PE/collective engine.
- Checks that the flit's destination matches the local node coordinates.
- Buffers accepted flits in a small FIFO.
- Presents the unpacked fields on a valid/ready interface.
- Drops and counts malformed or misrouted flits.

Parameters:
- FLIT_W, 82, flit width. Field map: payload[31:0], op[35:32], algtype[37:36], tag[45:38], contextId[53:46], rank[62:54], src_x[65:63], src_y[68:66], src_z[71:69], dst_x[74:72], dst_y[77:75], dst_z[80:78], valid[81].
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- my_x, my_y, my_z  in  3 each  local node coordinates; quasi-static
- in_flit  in  82  flit from the ejection port
- in_valid  in  1  in_flit is presented
- in_ready  out  1  depacketer can consume this cycle
- out_valid  out  1  head entry is available
- out_ready  in  1  consumer takes the head entry
- out_payload  out  32  payload field
- out_op  out  4  op field
- out_algtype  out  2  algtype field
- out_tag  out  8  tag field
- out_context_id  out  8  contextId field
- out_rank  out  9  rank field
- out_src_x, out_src_y, out_src_z  out  3 each  source coordinates
- occupancy  out  log2(DEPTH)+1  number of stored entries
- drop_pulse  out  1  one-cycle pulse when a flit is discarded
- drop_cnt  out  CNT_W  saturating count of discarded flits

Behaviour:
- Reset (async assert, sync-style release on next clk edge):
  - Read and write pointers = 0, occupancy = 0, out_valid = 0.
  - All out_* data = 0, drop_pulse = 0, drop_cnt = 0.
  - in_ready = 1 as soon as reset deasserts.
  - Reset mid-operation discards all FIFO contents; no partial entry survives.
- in_ready = (occupancy < DEPTH). It is a function of registered state only and has no combinational path from out_ready.
- Consume: in_valid & in_ready at a rising edge.
- A consumed flit is classified in the same cycle:
  - Discard if in_flit[81] == 0, or if (dst_x, dst_y, dst_z) != (my_x, my_y, my_z).
  - Discarded flits are not stored. drop_pulse = 1 in the following cycle. drop_cnt increments by 1 and saturates at all-ones.
  - Otherwise the flit is stored. The stored entry is bits [71:0]: dst and valid are stripped after the check.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- Output:
  - out_valid = (occupancy != 0).
  - All out_* fields are driven from the head entry, registered-read, and stable while out_valid = 1 and out_ready = 0.
  - When empty, out_* hold their last value; consumers must qualify with out_valid.
- Latency: a flit stored at edge N shows out_valid = 1 in the cycle after edge N. There is no same-cycle bypass from in_flit to the outputs.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - When full, in_ready = 0, so a same-cycle pop does not allow a push; the push happens the next cycle.
  - Push of a discarded flit together with a pop: occupancy decreases by 1.
- Pointers wrap modulo DEPTH. occupancy never exceeds DEPTH and never underflows, because pop is gated by out_valid.
- Ordering: strict FIFO order of stored flits. Discarded flits leave no gap.
- in_valid with in_ready = 0: nothing happens. The sender must hold in_flit; this is the router's duty.

Test Plan:
- Single flit to local node (my = 1,2,3), payload 0xDEADBEEF, op 4'h5, tag 8'hA7, rank 9'd300, src 4,5,6, valid bit set -> the next cycle shows out_valid = 1 with all fields exact; out_ready = 1 then gives out_valid = 0 and occupancy 0.
- Misrouted flit (dst 1,2,4) and a flit with bit81 = 0 -> neither is stored; drop_pulse asserts for 1 cycle each; drop_cnt = 2; out_valid stays 0.
- Fill to DEPTH = 4 with out_ready = 0 (payloads 1..4) -> in_ready = 0 after the 4th push; a 5th flit is held and not lost. Then pulse out_ready once -> in_ready = 1, the 5th is accepted, and the drain order is 1,2,3,4,5.
- Continuous stream of 10 flits with in_valid = 1 and out_ready = 1 every cycle -> occupancy ≤ 1 throughout; all 10 payloads come out in order at 1 per cycle.
- Assert rst_n low mid-stream with 3 entries stored -> out_valid = 0, occupancy = 0, drop_cnt = 0 immediately, without waiting for a clock edge; no stale entry appears after release.
- Force drop_cnt to near saturation (2^16 - 2 drops, or CNT_W = 2 build with 5 drops) -> the counter holds at all-ones and does not wrap.

Source files
------------

// File: rtl/flit_depacketer.sv
// Ejection-side flit depacketer: checks the destination, buffers local flits in a
// small FIFO and presents the unpacked header fields and payload on a valid/ready port.
module flit_depacketer #(
    parameter int FLIT_W = 82,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               my_x,
    input  logic [2:0]               my_y,
    input  logic [2:0]               my_z,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_payload,
    output logic [3:0]               out_op,
    output logic [1:0]               out_algtype,
    output logic [7:0]               out_tag,
    output logic [7:0]               out_context_id,
    output logic [8:0]               out_rank,
    output logic [2:0]               out_src_x,
    output logic [2:0]               out_src_y,
    output logic [2:0]               out_src_z,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PW      = $clog2(DEPTH);
    localparam int ENTRY_W = 72;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]        occ_q, occ_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic               drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               consume, flit_ok, push, pop;

    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != '0);
    assign consume   = in_valid & in_ready;
    assign flit_ok   = in_flit[81]
                     & (in_flit[74:72] == my_x)
                     & (in_flit[77:75] == my_y)
                     & (in_flit[80:78] == my_z);
    assign push      = consume & flit_ok;
    assign pop       = out_valid & out_ready;

    always_comb begin
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        occ_d        = occ_q + (PW+1)'(push) - (PW+1)'(pop);
        drop_pulse_d = consume & ~flit_ok;
        drop_cnt_d   = drop_cnt_q;
        if (drop_pulse_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        // The head register tracks the entry that will sit at the read pointer after
        // this edge; a push into an empty (or just-emptied) FIFO lands there directly.
        head_d = head_q;
        if (occ_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_flit[ENTRY_W-1:0];
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit[ENTRY_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            head_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_payload    = head_q[31:0];
    assign out_op         = head_q[35:32];
    assign out_algtype    = head_q[37:36];
    assign out_tag        = head_q[45:38];
    assign out_context_id = head_q[53:46];
    assign out_rank       = head_q[62:54];
    assign out_src_x      = head_q[65:63];
    assign out_src_y      = head_q[68:66];
    assign out_src_z      = head_q[71:69];
    assign occupancy      = occ_q;
    assign drop_pulse     = drop_pulse_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_flit_depacketer.sv
// Bench for flit_depacketer: directed and random flits against a queue-based model;
// a second instance built with a 2-bit drop counter exercises counter saturation.
module tb_flit_depacketer;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  my_x = 3'd1, my_y = 3'd2, my_z = 3'd3;
    logic [81:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, drop_pulse;
    logic [31:0] out_payload;
    logic [3:0]  out_op;
    logic [1:0]  out_algtype;
    logic [7:0]  out_tag, out_context_id;
    logic [8:0]  out_rank;
    logic [2:0]  out_src_x, out_src_y, out_src_z;
    logic [OW-1:0] occupancy;
    logic [15:0] drop_cnt;

    logic        s_in_ready, s_out_valid, s_drop_pulse;
    logic [31:0] s_payload;
    logic [3:0]  s_op;
    logic [1:0]  s_alg;
    logic [7:0]  s_tag, s_ctx;
    logic [8:0]  s_rank;
    logic [2:0]  s_sx, s_sy, s_sz;
    logic [OW-1:0] s_occ;
    logic [1:0]  s_drop_cnt;

    always #5 clk = ~clk;

    flit_depacketer #(.FLIT_W(82), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y), .my_z(my_z),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_op(out_op), .out_algtype(out_algtype),
        .out_tag(out_tag), .out_context_id(out_context_id), .out_rank(out_rank),
        .out_src_x(out_src_x), .out_src_y(out_src_y), .out_src_z(out_src_z),
        .occupancy(occupancy), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    flit_depacketer #(.FLIT_W(82), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y), .my_z(my_z),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_payload(s_payload), .out_op(s_op), .out_algtype(s_alg),
        .out_tag(s_tag), .out_context_id(s_ctx), .out_rank(s_rank),
        .out_src_x(s_sx), .out_src_y(s_sy), .out_src_z(s_sz),
        .occupancy(s_occ), .drop_pulse(s_drop_pulse), .drop_cnt(s_drop_cnt)
    );

    // Reference model: stored entries in arrival order plus drop bookkeeping.
    logic [71:0] q[$];
    int unsigned drops = 0, drops2 = 0;
    logic        exp_pulse = 1'b0;
    logic [71:0] last_head = '0;
    int          n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 72'(in_ready), 72'(q.size() < DEPTH));
        chk("out_valid", 72'(out_valid), 72'(q.size() != 0));
        chk("occupancy", 72'(occupancy), 72'(q.size()));
        chk("drop_pulse", 72'(drop_pulse), 72'(exp_pulse));
        chk("drop_cnt", 72'(drop_cnt), 72'(drops));
        chk("sat_drop_cnt", 72'(s_drop_cnt), 72'(drops2));
        if (q.size() != 0) last_head = q[0];
        chk("head_fields", {out_src_z, out_src_y, out_src_x, out_rank, out_context_id,
                            out_tag, out_algtype, out_op, out_payload}, last_head);
    endtask

    function automatic logic [81:0] mk(input logic [31:0] pay, input logic [3:0] op,
                                       input logic [1:0] alg, input logic [7:0] tag,
                                       input logic [7:0] ctx, input logic [8:0] rank,
                                       input logic [2:0] sx, input logic [2:0] sy,
                                       input logic [2:0] sz, input logic [2:0] dx,
                                       input logic [2:0] dy, input logic [2:0] dz,
                                       input logic v);
        return {v, dz, dy, dx, sz, sy, sx, rank, ctx, tag, alg, op, pay};
    endfunction

    function automatic logic [81:0] local_flit(input logic [31:0] pay);
        return mk(pay, 4'h1, 2'b01, 8'h10, 8'h20, 9'd7, 3'd0, 3'd0, 3'd0,
                  my_x, my_y, my_z, 1'b1);
    endfunction

    task automatic cycle(input logic iv, input logic [81:0] f, input logic ordy);
        logic acc, do_pop;
        in_valid  = iv;
        in_flit   = f;
        out_ready = ordy;
        acc    = iv && (q.size() < DEPTH);
        do_pop = ordy && (q.size() != 0);
        if (do_pop) void'(q.pop_front());
        exp_pulse = 1'b0;
        if (acc) begin
            if (f[81] && f[74:72] == my_x && f[77:75] == my_y && f[80:78] == my_z) begin
                q.push_back(f[71:0]);
            end else begin
                exp_pulse = 1'b1;
                if (drops < 65535) drops++;
                if (drops2 < 3) drops2++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [81:0] f;
        logic        iv, ordy, held;
        logic [2:0]  dx, dy, dz;

        // Reset: everything cleared while rst_n is low, in_ready already high.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);

        // Single local flit, fields exact on the next cycle, then popped.
        cycle(1'b1, mk(32'hDEADBEEF, 4'h5, 2'b10, 8'hA7, 8'h3C, 9'd300, 3'd4, 3'd5, 3'd6,
                       3'd1, 3'd2, 3'd3, 1'b1), 1'b0);
        chk("t1_payload", 72'(out_payload), 72'(32'hDEADBEEF));
        chk("t1_op", 72'(out_op), 72'(4'h5));
        chk("t1_tag", 72'(out_tag), 72'(8'hA7));
        chk("t1_rank", 72'(out_rank), 72'(9'd300));
        chk("t1_src", 72'({out_src_x, out_src_y, out_src_z}), 72'({3'd4, 3'd5, 3'd6}));
        cycle(1'b0, '0, 1'b1);

        // Misrouted flit and a flit with the valid bit clear are both dropped.
        cycle(1'b1, mk(32'h11, 4'h0, 2'b00, 8'h0, 8'h0, 9'd0, 3'd0, 3'd0, 3'd0,
                       3'd1, 3'd2, 3'd4, 1'b1), 1'b0);
        cycle(1'b1, mk(32'h22, 4'h0, 2'b00, 8'h0, 8'h0, 9'd0, 3'd0, 3'd0, 3'd0,
                       3'd1, 3'd2, 3'd3, 1'b0), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t2_drop_cnt", 72'(drop_cnt), 72'(2));

        // Fill to DEPTH, hold a 5th flit, then one pop lets it in; drain in order.
        for (int i = 1; i <= 4; i++) cycle(1'b1, local_flit(32'(i)), 1'b0);
        cycle(1'b1, local_flit(32'd5), 1'b0);
        cycle(1'b1, local_flit(32'd5), 1'b0);
        cycle(1'b1, local_flit(32'd5), 1'b1);
        cycle(1'b1, local_flit(32'd5), 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk("t3_drain_order", 72'(out_payload), 72'(i));
            cycle(1'b0, '0, 1'b1);
        end

        // Continuous stream with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, local_flit(32'h100 + 32'(i)), 1'b1);
            chk("t4_occ_le1", 72'(occupancy <= 1), 72'(1));
            chk("t4_payload", 72'(out_payload), 72'(32'h100 + 32'(i)));
        end
        cycle(1'b0, '0, 1'b1);

        // Random traffic; the sender holds a flit until it is accepted.
        held = 1'b0;
        iv   = 1'b0;
        f    = '0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                iv = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) != 0) begin
                    dx = my_x; dy = my_y; dz = my_z;
                end else begin
                    dx = 3'($urandom); dy = 3'($urandom); dz = 3'($urandom);
                end
                f = {($urandom_range(0, 7) != 0), dz, dy, dx,
                     $urandom, $urandom, 8'($urandom)};
            end
            ordy = ($urandom_range(0, 2) != 0);
            held = iv && (q.size() >= DEPTH);
            cycle(iv, f, ordy);
        end
        if (drops >= 4) chk("sat_holds_ones", 72'(s_drop_cnt), 72'(2'b11));

        // Asynchronous reset with entries stored clears state without a clock edge.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, local_flit(32'hA00 + 32'(i)), 1'b0);
        chk("t5_pre_occ", 72'(occupancy), 72'(3));
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        drops = 0;
        drops2 = 0;
        exp_pulse = 1'b0;
        last_head = '0;
        chk("t5_async_out_valid", 72'(out_valid), 72'(0));
        chk("t5_async_occ", 72'(occupancy), 72'(0));
        chk("t5_async_drop_cnt", 72'(drop_cnt), 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, local_flit(32'hB0), 1'b0);
        cycle(1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
